instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL provide parameter ROM_BYTES, default 32, giving the byte size of the instruction ROM; fetch addresses >= ROM_BYTES are out of range.
REQ-002 SHALL provide parameter RESET_PC, default 16'h0000, giving the first fetch address after reset.
REQ-003 SHALL use a single clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  downstream hold; freezes PC and the IF outputs.
REQ-007 br_taken  input  1  one-cycle redirect request.
REQ-008 br_target  input  16  redirect byte address; bit 0 is ignored.
REQ-009 dbg_req  input  1  debug ROM read request, level, held until dbg_ack.
REQ-010 dbg_addr  input  16  debug read byte address; stable while dbg_req is high.
REQ-011 mem_pc  output  16  address to the ROM pc port; combinational from state.
REQ-012 mem_instr  input  16  ROM instruction word, combinational return for mem_pc.
REQ-013 if_instr  output  16  registered fetched instruction.
REQ-014 if_pc  output  16  registered address of if_instr.
REQ-015 if_valid  output  1  if_instr/if_pc hold a valid fetch.
REQ-016 dbg_data  output  16  registered debug read result, valid when dbg_ack is high.
REQ-017 dbg_ack  output  1  one-cycle pulse completing a debug read.
REQ-018 halted  output  1  high while the FSM is in HALT.

Function
REQ-019 SHALL implement FSM states FETCH, DBG and HALT with a 16-bit PC register; the PC LSB is always 0.
REQ-020 In FETCH with stall=0 and br_taken=0 and dbg_req=0, each cycle SHALL:
- drive mem_pc=PC;
- register if_instr<=mem_instr, if_pc<=PC, if_valid<=1;
- set PC<=PC+2 (16-bit, modulo 2^16).
REQ-021 Fetch latency SHALL be one cycle: a word addressed in cycle N appears on if_instr after edge N+1.
REQ-022 br_taken=1 SHALL take priority over stall and dbg_req in every state:
- PC<=br_target & 16'hFFFE;
- if_valid<=0 for that edge (flush);
- next state FETCH, or HALT if the masked target >= ROM_BYTES.
REQ-023 stall=1 without br_taken SHALL hold PC, if_instr, if_pc, if_valid and the state; a pending dbg_req is not granted during stall.
REQ-024 dbg_req=1 in FETCH or HALT, with stall=0 and br_taken=0, SHALL move to DBG; in the DBG cycle:
- mem_pc=dbg_addr;
- dbg_data<=(dbg_addr<ROM_BYTES ? mem_instr : 16'h0000);
- dbg_ack<=1;
- if_valid<=0;
- PC held.
REQ-025 DBG SHALL last exactly one cycle, then return to the state it was entered from; dbg_req still high on the following cycle starts a new read only after one intervening normal cycle.
REQ-026 When PC>=ROM_BYTES at the start of a FETCH cycle, SHALL enter HALT instead of fetching: if_valid<=0, PC unchanged.
REQ-027 In HALT:
- halted=1 and if_valid=0;
- mem_pc=PC, except in DBG;
- exit only through br_taken to an in-range target, or through reset.
REQ-028 If br_taken and dbg_req assert in the same cycle, the redirect SHALL be applied and the debug read granted on the next eligible cycle.
REQ-029 dbg_ack SHALL be high for exactly one cycle per granted read and low otherwise; dbg_data SHALL hold its last value between reads.

Reset
REQ-030 While rst=1, and immediately on its assertion:
- PC=RESET_PC;
- state=FETCH;
- if_instr=0, if_pc=0, if_valid=0;
- dbg_data=0, dbg_ack=0, halted=0.
REQ-031 Reset asserted mid-DBG SHALL abort the read with no dbg_ack; reset mid-HALT SHALL clear halted.
REQ-032 The first fetch SHALL occur on the first rising edge after rst deasserts.

Verification
REQ-033 Sequential fetch: ROM[0]=16'h8080, ROM[1]=16'h8101, release reset, stall=0.
- Required: if_pc 0,2,4,... on consecutive cycles.
- Required: if_instr 16'h8080 then 16'h8101, if_valid=1 from the first edge.
REQ-034 Branch: br_taken=1 with br_target=16'h0007 while if_pc=4.
- Required: one cycle if_valid=0, then if_pc=6.
- Required: no fetch from address 7.
REQ-035 End-of-ROM: free-run from 0 with ROM_BYTES=32.
- Required: last valid if_pc=30, then halted=1 and if_valid=0.
- Then br_taken to 0: halted=0 and if_pc=0 one cycle later.
REQ-036 Debug read: dbg_req=1, dbg_addr=2 during fetch.
- Required: one-cycle dbg_ack with dbg_data=16'h8101, if_valid=0 that cycle.
- Required: fetch resumes at the held PC with no skipped address.
- Repeat with dbg_addr=40: dbg_data=0.
REQ-037 Simultaneous events:
- stall=1 for 3 cycles: outputs frozen.
- stall=1 with br_taken=1: redirect applied.
- br_taken with dbg_req: redirect first, dbg_ack one cycle later.
REQ-038 Reset mid-operation: assert rst asynchronously between edges while in DBG.
- Required: outputs reach reset values before the next edge.
- Required: no dbg_ack pulse.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: sequential PC fetch with one-cycle ROM latency,
// branch redirect, single-cycle debug ROM reads and an out-of-range HALT state.
//
// state    | meaning
// ST_FETCH | normal sequential fetch from PC
// ST_DBG   | one-cycle debug read of dbg_addr, then return to entry state
// ST_HALT  | PC ran past the ROM; waiting for a redirect or reset
module instr_fetch_ctrl #(
  parameter int          ROM_BYTES = 32,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        dbg_req,
  input  logic [15:0] dbg_addr,
  output logic [15:0] mem_pc,
  input  logic [15:0] mem_instr,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic [15:0] dbg_data,
  output logic        dbg_ack,
  output logic        halted
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DBG   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [16:0] ROM_LIMIT = 17'(ROM_BYTES);

  function automatic logic in_rom(input logic [15:0] addr);
    return {1'b0, addr} < ROM_LIMIT;
  endfunction

  logic [1:0]  state_q, state_d;
  logic        ret_halt_q, ret_halt_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] dbg_data_q, dbg_data_d;
  logic        dbg_ack_q, dbg_ack_d;

  logic [15:0] br_pc;
  logic        dbg_grant_ok;

  assign br_pc = br_target & 16'hFFFE;
  // The cycle right after an ack is always a normal cycle, even if dbg_req is still high.
  assign dbg_grant_ok = dbg_req && !dbg_ack_q;

  assign mem_pc = (state_q == ST_DBG) ? dbg_addr : pc_q;

  always_comb begin
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    dbg_data_d = dbg_data_q;
    dbg_ack_d  = 1'b0;

    if (br_taken) begin
      pc_d       = br_pc;
      if_valid_d = 1'b0;
      state_d    = in_rom(br_pc) ? ST_FETCH : ST_HALT;
    end else if (!stall) begin
      case (state_q)
        ST_FETCH: begin
          if (dbg_grant_ok) begin
            state_d    = ST_DBG;
            ret_halt_d = 1'b0;
            if_valid_d = 1'b0;
          end else if (!in_rom(pc_q)) begin
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
          end else begin
            if_instr_d = mem_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 16'd2;
          end
        end
        ST_HALT: begin
          if_valid_d = 1'b0;
          if (dbg_grant_ok) begin
            state_d    = ST_DBG;
            ret_halt_d = 1'b1;
          end
        end
        ST_DBG: begin
          dbg_data_d = in_rom(dbg_addr) ? mem_instr : 16'h0000;
          dbg_ack_d  = 1'b1;
          if_valid_d = 1'b0;
          state_d    = ret_halt_q ? ST_HALT : ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      ret_halt_q <= 1'b0;
      pc_q       <= RESET_PC & 16'hFFFE;
      if_instr_q <= 16'h0000;
      if_pc_q    <= 16'h0000;
      if_valid_q <= 1'b0;
      dbg_data_q <= 16'h0000;
      dbg_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      dbg_data_q <= dbg_data_d;
      dbg_ack_q  <= dbg_ack_d;
    end
  end

  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign dbg_data = dbg_data_q;
  assign dbg_ack  = dbg_ack_q;
  assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: directed phases push expected fetches
// and debug reads; a negedge monitor pops and compares as the DUT presents them.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        dbg_req = 1'b0;
  logic [15:0] dbg_addr = 16'h0000;
  logic [15:0] mem_pc;
  logic [15:0] mem_instr;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic [15:0] dbg_data;
  logic        dbg_ack;
  logic        halted;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_pc_q[$];
  logic [15:0] exp_in_q[$];
  logic [15:0] exp_dbg_q[$];
  logic        stall_e = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.ROM_BYTES(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .mem_pc(mem_pc), .mem_instr(mem_instr),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .dbg_data(dbg_data),
    .dbg_ack(dbg_ack), .halted(halted)
  );

  // ROM contents: word i = 8080 + i*0081, so word0=8080, word1=8101, word2=8182.
  function automatic logic [15:0] rom_word(input logic [14:0] i);
    return 16'h8080 + ({1'b0, i} * 16'h0081);
  endfunction

  assign mem_instr = (mem_pc < 16'd32) ? rom_word(mem_pc[15:1]) : 16'hBAD0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [15:0] pc);
    exp_pc_q.push_back(pc);
    exp_in_q.push_back(rom_word(pc[15:1]));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_if_valid"}, {15'b0, if_valid}, 16'h0);
    chk({tag, "_if_pc"}, if_pc, 16'h0);
    chk({tag, "_if_instr"}, if_instr, 16'h0);
    chk({tag, "_dbg_ack"}, {15'b0, dbg_ack}, 16'h0);
    chk({tag, "_dbg_data"}, dbg_data, 16'h0);
    chk({tag, "_halted"}, {15'b0, halted}, 16'h0);
    chk({tag, "_mem_pc"}, mem_pc, 16'h0);
  endtask

  always @(posedge clk) stall_e <= stall;

  // Monitor: new fetch appears when if_valid is high and the last edge was not stalled.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid && !stall_e) begin
        if (exp_pc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fetch: got pc %h instr %h expected none", if_pc, if_instr);
        end else begin
          logic [15:0] epc, ein;
          epc = exp_pc_q.pop_front();
          ein = exp_in_q.pop_front();
          chk("fetch_pc", if_pc, epc);
          chk("fetch_instr", if_instr, ein);
        end
      end
      if (dbg_ack) begin
        if (exp_dbg_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_dbg_ack: got data %h expected no ack", dbg_data);
        end else begin
          logic [15:0] ed;
          ed = exp_dbg_q.pop_front();
          chk("dbg_data", dbg_data, ed);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    // Sequential fetch: first edge after release fetches PC 0
    push_fetch(16'd0); push_fetch(16'd2); push_fetch(16'd4);
    step();
    chk("first_valid", {15'b0, if_valid}, 16'h1);
    step(); step();

    // Branch to odd target 7 while if_pc=4: flush, then fetch from 6
    br_taken = 1'b1; br_target = 16'h0007;
    step();
    chk("br_flush_valid", {15'b0, if_valid}, 16'h0);
    chk("br_mem_pc", mem_pc, 16'h0006);
    br_taken = 1'b0;
    push_fetch(16'd6); push_fetch(16'd8);
    step(); step();

    // Stall for 3 cycles: outputs frozen
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_if_pc", if_pc, 16'h0008);
      chk("stall_if_instr", if_instr, rom_word(15'd4));
      chk("stall_if_valid", {15'b0, if_valid}, 16'h1);
    end

    // Stall together with branch: redirect wins
    br_taken = 1'b1; br_target = 16'h0010;
    step();
    chk("stall_br_valid", {15'b0, if_valid}, 16'h0);
    chk("stall_br_mem_pc", mem_pc, 16'h0010);
    stall = 1'b0; br_taken = 1'b0;
    push_fetch(16'd16); push_fetch(16'd18);
    step(); step();

    // Debug read of addr 2 during fetch; PC held at 20
    dbg_req = 1'b1; dbg_addr = 16'h0002;
    exp_dbg_q.push_back(16'h8101);
    step();
    chk("dbg_mem_pc", mem_pc, 16'h0002);
    chk("dbg_enter_valid", {15'b0, if_valid}, 16'h0);
    step();
    chk("dbg_ack_pulse", {15'b0, dbg_ack}, 16'h1);
    chk("dbg_ack_valid", {15'b0, if_valid}, 16'h0);
    dbg_req = 1'b0;
    push_fetch(16'd20); push_fetch(16'd22);
    step();
    chk("dbg_ack_drop", {15'b0, dbg_ack}, 16'h0);
    step();

    // Out-of-range debug read; request held past the ack for one cycle
    dbg_req = 1'b1; dbg_addr = 16'd40;
    exp_dbg_q.push_back(16'h0000);
    step(); step();
    push_fetch(16'd24);
    step();
    chk("dbg_gap_ack", {15'b0, dbg_ack}, 16'h0);
    chk("dbg_gap_pc", if_pc, 16'd24);
    dbg_req = 1'b0;
    chk("dbg_hold_data", dbg_data, 16'h0000);
    push_fetch(16'd26);
    step();

    // Branch and debug request together: redirect first, read afterwards
    br_taken = 1'b1; br_target = 16'h0000; dbg_req = 1'b1; dbg_addr = 16'h0000;
    exp_dbg_q.push_back(16'h8080);
    step();
    chk("brdbg_ack0", {15'b0, dbg_ack}, 16'h0);
    chk("brdbg_valid", {15'b0, if_valid}, 16'h0);
    br_taken = 1'b0;
    step();
    chk("brdbg_ack1", {15'b0, dbg_ack}, 16'h0);
    step();
    chk("brdbg_ack2", {15'b0, dbg_ack}, 16'h1);
    dbg_req = 1'b0;

    // Free-run to end of ROM
    for (int a = 0; a < 32; a += 2) push_fetch(16'(a));
    repeat (16) step();
    chk("eor_last_pc", if_pc, 16'd30);
    chk("eor_not_halted", {15'b0, halted}, 16'h0);
    step();
    chk("eor_halted", {15'b0, halted}, 16'h1);
    chk("eor_valid", {15'b0, if_valid}, 16'h0);
    chk("eor_mem_pc", mem_pc, 16'd32);
    step();
    chk("eor_still_halted", {15'b0, halted}, 16'h1);

    // Debug read from HALT returns to HALT
    dbg_req = 1'b1; dbg_addr = 16'h0004;
    exp_dbg_q.push_back(16'h8182);
    step();
    chk("halt_dbg_mem_pc", mem_pc, 16'h0004);
    step();
    chk("halt_dbg_ack", {15'b0, dbg_ack}, 16'h1);
    chk("halt_dbg_back", {15'b0, halted}, 16'h1);
    dbg_req = 1'b0;

    // Exit HALT by branching to 0
    br_taken = 1'b1; br_target = 16'h0000;
    step();
    chk("halt_exit", {15'b0, halted}, 16'h0);
    chk("halt_exit_valid", {15'b0, if_valid}, 16'h0);
    br_taken = 1'b0;
    push_fetch(16'd0);
    step();
    chk("halt_exit_pc", if_pc, 16'd0);

    // Reset asserted between edges while in DBG: aborts read, no ack
    dbg_req = 1'b1; dbg_addr = 16'h0002;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_dbg");
    step();
    chk("rst_hold_ack", {15'b0, dbg_ack}, 16'h0);
    step();
    chk("rst_hold_ack2", {15'b0, dbg_ack}, 16'h0);
    rst = 1'b0; dbg_req = 1'b0;
    push_fetch(16'd0); push_fetch(16'd2);
    step(); step();
    @(negedge clk);
    #1;
    chk("fetch_q_empty", 16'(exp_pc_q.size()), 16'd0);
    chk("dbg_q_empty", 16'(exp_dbg_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
